// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: address map, Zicsr funct3
// encodings and the read-modify-write operation kinds.
package csr_pkg;

    localparam logic [11:0] CSR_TOHOST    = 12'h51E;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    // The low two funct3 bits pick the operation; bit 2 only selects the operand source.
    function automatic csr_op_e decode_op(input logic [2:0] funct3);
        csr_op_e kind;
        case (funct3[1:0])
            2'b01:   kind = OP_RW;
            2'b10:   kind = OP_RS;
            2'b11:   kind = OP_RC;
            default: kind = OP_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running counter with independently writable lo/hi halves. A write to
// either half wins over the increment and leaves the other half untouched.
module csr_counter64 #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [XLEN-1:0]  wdata,
    output logic [CNT_W-1:0] q
);

    localparam int HI_W = CNT_W - XLEN;

    // Writing one half suppresses the increment for that edge, so no carry can
    // leak into the unwritten half.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (wr_lo) begin
            q[XLEN-1:0] <= wdata;
        end else if (wr_hi) begin
            q[CNT_W-1:XLEN] <= wdata[HI_W-1:0];
        end else if (inc) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Execute-stage Zicsr unit: decodes CSR ops, returns the old value
// combinationally and commits the read-modify-write on the next clock edge.
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              CNT_W        = 64,
    parameter bit              HAS_COUNTERS = 1'b1,
    parameter logic [XLEN-1:0] TOHOST_RST   = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_en,
    input  logic [2:0]      csr_funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs1_zimm,
    input  logic            instret_inc,
    input  logic            stall,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    output logic [XLEN-1:0] tohost
);

    localparam int HI_W = CNT_W - XLEN;

    csr_op_e          op_kind;
    logic [XLEN-1:0]  operand;
    logic             wr_attempt;
    logic             addr_hit;
    logic [XLEN-1:0]  old_val;
    logic [XLEN-1:0]  new_val;
    logic             commit;
    logic [XLEN-1:0]  mscratch_q;
    logic [CNT_W-1:0] mcycle_q;
    logic [CNT_W-1:0] minstret_q;
    logic [XLEN-1:0]  mcycle_hi;
    logic [XLEN-1:0]  minstret_hi;

    assign op_kind = decode_op(csr_funct3);
    assign operand = csr_funct3[2] ? {{(XLEN-5){1'b0}}, rs1_zimm} : rs1_data;

    // Set/clear with a zero rs1/zimm field is a pure read, which keeps
    // "CSRRS x0" on the read-only aliases legal.
    assign wr_attempt = (op_kind == OP_RW) || ((op_kind != OP_NONE) && (rs1_zimm != 5'd0));

    always_comb begin
        mcycle_hi   = '0;
        minstret_hi = '0;
        mcycle_hi[HI_W-1:0]   = mcycle_q[CNT_W-1:XLEN];
        minstret_hi[HI_W-1:0] = minstret_q[CNT_W-1:XLEN];
    end

    always_comb begin
        addr_hit = 1'b0;
        old_val  = '0;
        case (csr_addr)
            CSR_TOHOST: begin
                addr_hit = 1'b1;
                old_val  = tohost;
            end
            CSR_MSCRATCH: begin
                addr_hit = 1'b1;
                old_val  = mscratch_q;
            end
            CSR_MCYCLE, CSR_CYCLE: begin
                addr_hit = HAS_COUNTERS;
                old_val  = mcycle_q[XLEN-1:0];
            end
            CSR_MCYCLEH, CSR_CYCLEH: begin
                addr_hit = HAS_COUNTERS;
                old_val  = mcycle_hi;
            end
            CSR_MINSTRET, CSR_INSTRET: begin
                addr_hit = HAS_COUNTERS;
                old_val  = minstret_q[XLEN-1:0];
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
                addr_hit = HAS_COUNTERS;
                old_val  = minstret_hi;
            end
            default: begin
                addr_hit = 1'b0;
                old_val  = '0;
            end
        endcase
    end

    assign csr_illegal = csr_en && (!addr_hit || (op_kind == OP_NONE)
                                    || (wr_attempt && (csr_addr[11:10] == 2'b11)));
    assign csr_rdata   = (csr_en && !csr_illegal) ? old_val : '0;
    assign commit      = csr_en && wr_attempt && !csr_illegal && !stall;

    always_comb begin
        new_val = old_val;
        case (op_kind)
            OP_RW:   new_val = operand;
            OP_RS:   new_val = old_val | operand;
            OP_RC:   new_val = old_val & ~operand;
            default: new_val = old_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tohost     <= TOHOST_RST;
            mscratch_q <= '0;
        end else if (commit) begin
            if (csr_addr == CSR_TOHOST)   tohost     <= new_val;
            if (csr_addr == CSR_MSCRATCH) mscratch_q <= new_val;
        end
    end

    // Only the machine-mode addresses can commit; the user aliases are read-only.
    if (HAS_COUNTERS) begin : g_counters
        csr_counter64 #(.XLEN(XLEN), .CNT_W(CNT_W)) u_mcycle (
            .clk   (clk),
            .rst   (rst),
            .inc   (1'b1),
            .wr_lo (commit && (csr_addr == CSR_MCYCLE)),
            .wr_hi (commit && (csr_addr == CSR_MCYCLEH)),
            .wdata (new_val),
            .q     (mcycle_q)
        );

        csr_counter64 #(.XLEN(XLEN), .CNT_W(CNT_W)) u_minstret (
            .clk   (clk),
            .rst   (rst),
            .inc   (instret_inc && !stall),
            .wr_lo (commit && (csr_addr == CSR_MINSTRET)),
            .wr_hi (commit && (csr_addr == CSR_MINSTRETH)),
            .wdata (new_val),
            .q     (minstret_q)
        );
    end else begin : g_no_counters
        assign mcycle_q   = '0;
        assign minstret_q = '0;
    end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed steps followed by random traffic,
// all compared against an architectural model of the CSR state.
module tb_csr_unit;

    logic        clk;
    logic        rst;
    logic        csr_en;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs1_zimm;
    logic        instret_inc;
    logic        stall;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] tohost;

    int checks;
    int failures;

    logic [31:0] m_tohost;
    logic [31:0] m_mscratch;
    logic [63:0] m_cycle;
    logic [63:0] m_instret;

    logic [31:0] last_rdata;
    logic        last_illegal;

    csr_unit dut (
        .clk         (clk),
        .rst         (rst),
        .csr_en      (csr_en),
        .csr_funct3  (csr_funct3),
        .csr_addr    (csr_addr),
        .rs1_data    (rs1_data),
        .rs1_zimm    (rs1_zimm),
        .instret_inc (instret_inc),
        .stall       (stall),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .tohost      (tohost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_mapped(input logic [11:0] a);
        case (a)
            12'h51E, 12'h340,
            12'hB00, 12'hB80, 12'hB02, 12'hB82,
            12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h51E:          return m_tohost;
            12'h340:          return m_mscratch;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            default:          return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare combinational outputs, then advance the model.
    task automatic step(input logic en, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] zimm,
                        input logic inc, input logic stl, input logic rs);
        logic        wr;
        logic        f3_ok;
        logic        ill;
        logic [31:0] exp_rdata;
        logic [31:0] old;
        logic [31:0] opnd;
        logic [31:0] nv;
        logic [63:0] nc;
        logic [63:0] ni;
        @(negedge clk);
        csr_en      = en;
        csr_funct3  = f3;
        csr_addr    = addr;
        rs1_data    = rs1;
        rs1_zimm    = zimm;
        instret_inc = inc;
        stall       = stl;
        rst         = rs;
        #1;
        wr        = (f3[1:0] == 2'b01) || (zimm != 5'd0);
        f3_ok     = (f3[1:0] != 2'b00);
        ill       = en && (!is_mapped(addr) || !f3_ok || (wr && addr[11:10] == 2'b11));
        old       = model_read(addr);
        exp_rdata = (en && !ill) ? old : 32'h0;
        last_rdata   = csr_rdata;
        last_illegal = csr_illegal;
        check("rdata", csr_rdata, exp_rdata);
        check("illegal", {31'b0, csr_illegal}, {31'b0, ill});
        check("tohost", tohost, m_tohost);
        @(posedge clk);
        if (rs) begin
            m_tohost   = 32'h0;
            m_mscratch = 32'h0;
            m_cycle    = 64'h0;
            m_instret  = 64'h0;
        end else begin
            opnd = f3[2] ? {27'b0, zimm} : rs1;
            if (f3[1:0] == 2'b01)      nv = opnd;
            else if (f3[1:0] == 2'b10) nv = old | opnd;
            else                       nv = old & ~opnd;
            nc = m_cycle + 64'd1;
            ni = m_instret + ((inc && !stl) ? 64'd1 : 64'd0);
            if (en && wr && !ill && !stl) begin
                case (addr)
                    12'h51E: m_tohost   = nv;
                    12'h340: m_mscratch = nv;
                    12'hB00: nc = {m_cycle[63:32], nv};
                    12'hB80: nc = {nv, m_cycle[31:0]};
                    12'hB02: ni = {m_instret[63:32], nv};
                    12'hB82: ni = {nv, m_instret[31:0]};
                    default: ;
                endcase
            end
            m_cycle   = nc;
            m_instret = ni;
        end
    endtask

    initial begin
        logic [11:0] addr_tab [0:11];
        checks   = 0;
        failures = 0;
        addr_tab = '{12'h51E, 12'h340, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                     12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h000};

        rst = 1'b1; csr_en = 1'b0; csr_funct3 = 3'b0; csr_addr = 12'h0;
        rs1_data = 32'h0; rs1_zimm = 5'h0; instret_inc = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        m_tohost = 32'h0; m_mscratch = 32'h0; m_cycle = 64'h0; m_instret = 64'h0;

        $display("[TB] reset state and cycle counter");
        step(1, 3'b010, 12'hC00, 32'h0, 5'd0, 0, 0, 0);
        check("cycle_after_reset", last_rdata, 32'd0);
        check("tohost_reset", tohost, 32'h0);
        step(1, 3'b010, 12'h340, 32'h0, 5'd0, 0, 0, 0);
        check("mscratch_reset", last_rdata, 32'h0);
        step(1, 3'b010, 12'hC82, 32'h0, 5'd0, 0, 0, 0);
        check("instreth_reset", last_rdata, 32'h0);
        repeat (7) step(0, 3'b000, 12'h000, 32'h0, 5'd0, 0, 0, 0);
        step(1, 3'b010, 12'hC00, 32'h0, 5'd0, 0, 0, 0);
        check("cycle_at_10", last_rdata, 32'd10);
        check("cycle_ro_read_legal", {31'b0, last_illegal}, 32'd0);
        step(1, 3'b001, 12'hC00, 32'h1234, 5'd1, 0, 0, 0);
        check("ro_write_illegal", {31'b0, last_illegal}, 32'd1);
        check("ro_write_rdata", last_rdata, 32'h0);

        $display("[TB] tohost and mscratch read-modify-write");
        step(1, 3'b001, 12'h51E, 32'hDEADBEEF, 5'd3, 0, 0, 0);
        check("tohost_old", last_rdata, 32'h0);
        step(0, 3'b000, 12'h000, 32'h0, 5'd0, 0, 0, 0);
        check("tohost_new", tohost, 32'hDEADBEEF);
        step(1, 3'b001, 12'h340, 32'hF0F0F0F0, 5'd0, 0, 0, 0);
        step(1, 3'b111, 12'h340, 32'hFFFFFFFF, 5'h0F, 0, 0, 0);
        check("rci_read", last_rdata, 32'hF0F0F0F0);
        step(1, 3'b110, 12'h340, 32'h0, 5'h1F, 0, 0, 0);
        check("rci_no_change", last_rdata, 32'hF0F0F0F0);
        step(1, 3'b010, 12'h340, 32'hFFFFFFFF, 5'd0, 0, 0, 0);
        check("rsi_result", last_rdata, 32'hF0F0F0FF);

        $display("[TB] counter carry and write priority");
        step(1, 3'b001, 12'hB80, 32'h0, 5'd2, 1, 0, 0);
        step(1, 3'b001, 12'hB00, 32'hFFFFFFFE, 5'd2, 1, 0, 0);
        repeat (3) step(0, 3'b000, 12'h000, 32'h0, 5'd0, 0, 0, 0);
        step(1, 3'b010, 12'hC00, 32'h0, 5'd0, 0, 0, 0);
        check("cycle_lo_carry", last_rdata, 32'd1);
        step(1, 3'b010, 12'hC80, 32'h0, 5'd0, 0, 0, 0);
        check("cycle_hi_carry", last_rdata, 32'd1);
        step(1, 3'b001, 12'hB02, 32'h100, 5'd4, 1, 0, 0);
        step(1, 3'b010, 12'hC02, 32'h0, 5'd0, 0, 0, 0);
        check("instret_write_wins", last_rdata, 32'h100);
        step(1, 3'b001, 12'hB02, 32'h555, 5'd4, 1, 1, 0);
        step(1, 3'b010, 12'hC02, 32'h0, 5'd0, 0, 0, 0);
        check("instret_stall", last_rdata, 32'h100);
        step(1, 3'b001, 12'hB00, 32'hFFFFFFFF, 5'd1, 0, 0, 0);
        step(1, 3'b010, 12'hC80, 32'h0, 5'd0, 0, 0, 0);
        check("no_carry_on_write", last_rdata, 32'd1);

        $display("[TB] illegal accesses and mid-run reset");
        step(1, 3'b000, 12'h340, 32'h1, 5'd1, 0, 0, 0);
        check("funct3_000_illegal", {31'b0, last_illegal}, 32'd1);
        step(1, 3'b001, 12'h7C0, 32'h1, 5'd1, 0, 0, 0);
        check("unmapped_illegal", {31'b0, last_illegal}, 32'd1);
        check("unmapped_rdata", last_rdata, 32'h0);
        step(0, 3'b001, 12'h340, 32'hAAAA5555, 5'd1, 0, 0, 0);
        step(1, 3'b001, 12'h340, 32'h12345678, 5'd1, 1, 0, 1);
        step(1, 3'b010, 12'h340, 32'h0, 5'd0, 0, 0, 0);
        check("mscratch_after_rst", last_rdata, 32'h0);
        check("tohost_after_rst", tohost, 32'h0);
        step(1, 3'b010, 12'hC00, 32'h0, 5'd0, 0, 0, 0);
        check("cycle_after_rst", last_rdata, 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic [11:0] a;
            a = addr_tab[$urandom_range(0, 11)];
            if (a == 12'h000) a = 12'($urandom);
            step(($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), a, $urandom,
                 (($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom)),
                 1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
